// File: rtl/gray_timestamp_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : gray_timestamp_fifo_if
//  Brief    : Bus bundle between the feedback controller and the timestamp FIFO.
//  Revision : 1.0
// ============================================================================
interface gray_timestamp_fifo_if #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   gray_in;
    logic               event_in;
    logic               rd_en;
    logic               ovf_clr;
    logic [WIDTH-1:0]   ts_out;
    logic [WIDTH-1:0]   delta_out;
    logic               valid;
    logic               full;
    logic [C_CNT_W-1:0] count;
    logic               overflow;

    modport master (
        output gray_in, event_in, rd_en, ovf_clr,
        input  ts_out, delta_out, valid, full, count, overflow
    );

    modport slave (
        input  gray_in, event_in, rd_en, ovf_clr,
        output ts_out, delta_out, valid, full, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/gray_timestamp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : gray_timestamp_fifo
//  Brief    : Synchronises a gray count, timestamps events, queues {ts, delta}.
//  Revision : 1.0
// ============================================================================
module gray_timestamp_fifo #(
    parameter int WIDTH       = 17,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    gray_timestamp_fifo_if.slave  bus
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   bin_q;
    logic [WIDTH-1:0]   last_ts_q;
    logic [WIDTH-1:0]   ts_mem_q [DEPTH];
    logic [WIDTH-1:0]   dl_mem_q [DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q;
    logic [C_PTR_W-1:0] rd_ptr_q;
    logic [C_CNT_W-1:0] count_q;
    logic [C_CNT_W-1:0] count_d;
    logic               overflow_q;
    logic               overflow_d;

    logic [WIDTH-1:0]   w_bin;
    logic [WIDTH-1:0]   w_cand_delta;
    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Binary bit i is the XOR of all gray bits from i up to the MSB.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) w_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end

    assign w_valid      = (count_q != '0);
    assign w_full       = (count_q == C_CNT_W'(DEPTH));
    assign w_pop        = bus.rd_en & w_valid;
    assign w_push       = bus.event_in & (~w_full | w_pop);
    assign w_drop       = bus.event_in & w_full & ~w_pop;
    assign w_cand_delta = bin_q - last_ts_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (w_drop)
            overflow_d = 1'b1;
        else if (bus.ovf_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q      <= '0;
            last_ts_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                ts_mem_q[e] <= '0;
                dl_mem_q[e] <= '0;
            end
        end else begin
            bin_q      <= w_bin;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (w_push) begin
                ts_mem_q[wr_ptr_q] <= bin_q;
                dl_mem_q[wr_ptr_q] <= w_cand_delta;
                wr_ptr_q           <= wr_ptr_q + C_PTR_W'(1);
                last_ts_q          <= bin_q;
            end
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + C_PTR_W'(1);
        end
    end

    assign bus.ts_out    = w_valid ? ts_mem_q[rd_ptr_q] : '0;
    assign bus.delta_out = w_valid ? dl_mem_q[rd_ptr_q] : '0;
    assign bus.valid     = w_valid;
    assign bus.full      = w_full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule
`default_nettype wire
